muldiv_sequencer: RTL and testbench

Multi-cycle sequencer and datapath for the RV32M multiply/divide instructions. It sits beside the single-cycle ALU in EX and is selected when an R-type instruction carries funct7 = 0000001. It holds the pipeline through a stall output while iterating one bit per cycle, then presents the result for exactly one cycle. Division-by-zero and signed-overflow cases bypass iteration.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_sequencer_if.sv | 25 ++
 rtl/muldiv_sequencer.sv | 157 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
// Operand signedness is decoded once here so that the datapath and any checker agree.
package muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_signed_a(funct3_e f);
    case (f)
      MUL, MULH, MULHSU, DIV, REM: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_b(funct3_e f);
    case (f)
      MUL, MULH, DIV, REM: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the EX stage and the multi-cycle mul/div unit.
// The master modport is the pipeline side, the slave modport is the sequencer.
interface muldiv_sequencer_if #(parameter int XLEN = 32);

  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, op_a, op_b,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b,
    output stall, busy, done, result
  );

endinterface

// File: rtl/muldiv_sequencer.sv
// Bit-serial RV32M multiply/divide unit: shift-add multiply and restoring division
// on unsigned magnitudes, with sign correction and divide-by-zero/overflow shortcuts.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;

  state_e          state_r;
  funct3_e         op_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN:0]   acc_r;
  logic [XLEN-1:0] lo_r;
  logic [XLEN-1:0] opb_r;
  logic [XLEN-1:0] result_r;
  logic            neg_r;

  funct3_e         op_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] a_mag_s;
  logic [XLEN-1:0] b_mag_s;
  logic            is_div_s;
  logic            is_rem_s;
  logic            sign_s;
  logic            div0_s;
  logic            ovf_s;
  logic            shortcut_s;
  logic [XLEN-1:0] short_res_s;

  // Decode the incoming request: magnitudes, result sign and shortcut result
  always_comb begin
    op_s     = funct3_e'(bus.funct3);
    a_neg_s  = is_signed_a(op_s) & bus.op_a[XLEN-1];
    b_neg_s  = is_signed_b(op_s) & bus.op_b[XLEN-1];
    a_mag_s  = a_neg_s ? -bus.op_a : bus.op_a;
    b_mag_s  = b_neg_s ? -bus.op_b : bus.op_b;
    is_div_s = bus.funct3[2];
    is_rem_s = bus.funct3[2] & bus.funct3[1];
    // A remainder follows the dividend; everything else follows the sign product
    if (is_rem_s) begin
      sign_s = a_neg_s;
    end else begin
      sign_s = a_neg_s ^ b_neg_s;
    end
    div0_s = is_div_s && (bus.op_b == {XLEN{1'b0}});
    ovf_s  = is_div_s && is_signed_a(op_s)
             && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
             && (bus.op_b == {XLEN{1'b1}});
    shortcut_s = div0_s | ovf_s;
    if (div0_s) begin
      short_res_s = is_rem_s ? bus.op_a : {XLEN{1'b1}};
    end else if (ovf_s) begin
      short_res_s = is_rem_s ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      short_res_s = {XLEN{1'b0}};
    end
  end

  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     shifted_s;
  logic              ge_s;
  logic [XLEN:0]     acc_nx_s;
  logic [XLEN-1:0]   lo_nx_s;
  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic [XLEN-1:0]   final_res_s;

  // One iteration of the shared datapath plus sign correction of the final step
  always_comb begin
    mul_sum_s = acc_r + (lo_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
    shifted_s = {acc_r[XLEN-1:0], lo_r[XLEN-1]};
    ge_s      = shifted_s >= {1'b0, opb_r};
    if (op_r[2]) begin
      acc_nx_s = ge_s ? (shifted_s - {1'b0, opb_r}) : shifted_s;
      lo_nx_s  = {lo_r[XLEN-2:0], ge_s};
    end else begin
      acc_nx_s = {1'b0, mul_sum_s[XLEN:1]};
      lo_nx_s  = {mul_sum_s[0], lo_r[XLEN-1:1]};
    end
    // Negating the whole product keeps the high half correct for MULH/MULHSU
    prod_s     = {acc_nx_s[XLEN-1:0], lo_nx_s};
    prod_fix_s = neg_r ? -prod_s : prod_s;
    quo_fix_s  = neg_r ? -lo_nx_s : lo_nx_s;
    rem_fix_s  = neg_r ? -acc_nx_s[XLEN-1:0] : acc_nx_s[XLEN-1:0];
    case (op_r)
      MUL:                final_res_s = prod_fix_s[XLEN-1:0];
      MULH, MULHSU, MULHU: final_res_s = prod_fix_s[2*XLEN-1:XLEN];
      DIV, DIVU:          final_res_s = quo_fix_s;
      REM, REMU:          final_res_s = rem_fix_s;
      default:            final_res_s = {XLEN{1'b0}};
    endcase
  end

  // Sequencer FSM with operand latches, iteration counter and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      op_r     <= MUL;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(XLEN+1){1'b0}};
      lo_r     <= {XLEN{1'b0}};
      opb_r    <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
      neg_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op_r  <= op_s;
            neg_r <= sign_s;
            cnt_r <= {CW{1'b0}};
            acc_r <= {(XLEN+1){1'b0}};
            if (shortcut_s) begin
              result_r <= short_res_s;
              state_r  <= DONE;
            end else begin
              // lo holds the multiplier or dividend, opb the multiplicand or divisor
              lo_r    <= is_div_s ? a_mag_s : b_mag_s;
              opb_r   <= is_div_s ? b_mag_s : a_mag_s;
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state_r <= IDLE;
          end else begin
            acc_r <= acc_nx_s;
            lo_r  <= lo_nx_s;
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CW'(XLEN - 1)) begin
              result_r <= final_res_s;
              state_r  <= DONE;
            end
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.stall  = ((state_r == IDLE) & bus.start & ~bus.flush) | (state_r == CALC);
  assign bus.busy   = (state_r == CALC);
  assign bus.done   = (state_r == DONE) & ~bus.flush;
  assign bus.result = result_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised self-checking bench for muldiv_sequencer against an arithmetic reference
// model and per-cycle expected stall/busy/done windows.
module tb_muldiv_sequencer;

  localparam int INF = 32'h7FFF_FFFF;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   chk_en   = 1'b0;

  // expected behaviour windows, in cycle numbers
  int          stall_lo = 1, stall_hi = 0;
  int          busy_lo  = 1, busy_hi  = 0;
  int          done_at  = -1;
  int          res_switch = INF;
  logic [31:0] res_old = 32'd0;
  logic [31:0] res_new = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_sequencer_if #(.XLEN(32)) bus ();
  muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic drive_garbage();
    bus.start  = 1'($urandom_range(0, 1));
    bus.funct3 = 3'($urandom);
    bus.op_a   = 32'($urandom);
    bus.op_b   = 32'($urandom);
  endtask

  // mode 0: normal, 1: flush in CALC at iteration fl_at, 2: flush during the done cycle
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input int fl_at);
    int          s, last;
    bit          sc, fl_calc;
    logic [31:0] r;
    s  = cyc;
    sc = f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    fl_calc = (mode == 1) && !sc;
    r  = ref_model(f, a, b);
    stall_lo = s;     stall_hi = sc ? s : s + 32;
    busy_lo  = s + 1; busy_hi  = sc ? s : s + 32;
    done_at  = sc ? s + 1 : s + 33;
    res_new  = r;
    res_switch = done_at;
    last = done_at;
    if (fl_calc) begin
      stall_hi = s + 1 + fl_at;
      busy_hi  = s + 1 + fl_at;
      done_at  = -1;
      res_switch = INF;
      last = s + 1 + fl_at;
    end else if (mode == 2) begin
      done_at = -1;
    end
    bus.start = 1'b1; bus.flush = 1'b0;
    bus.funct3 = f; bus.op_a = a; bus.op_b = b;
    do begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      if (cyc == last) begin
        if (fl_calc) begin
          bus.flush = 1'b1;
        end else begin
          drive_garbage();
          bus.start = 1'b1;
          bus.flush = (mode == 2);
        end
      end else if (cyc < last) begin
        drive_garbage();
      end
    end while (cyc <= last);
    bus.start = 1'b0; bus.flush = 1'b0;
    if (!fl_calc) res_old = r;
    res_switch = INF;
    stall_lo = 1; stall_hi = 0; busy_lo = 1; busy_hi = 0; done_at = -1;
  endtask

  // Per-cycle comparison of every output against the expected windows
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(bus.stall), 32'(cyc >= stall_lo && cyc <= stall_hi));
      check("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      check("done", 32'(bus.done), 32'(cyc == done_at));
      check("result", bus.result, (cyc >= res_switch) ? res_new : res_old);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0;
    bus.op_a = 32'd0; bus.op_b = 32'd0;

    // pin the reference model with hand-computed values
    check("model_mul",    ref_model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("model_mulhu",  ref_model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("model_mulh",   ref_model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0000);
    check("model_mulhsu", ref_model(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    check("model_div",    ref_model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_rem",    ref_model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("model_divu",   ref_model(3'd5, 32'd100, 32'd7), 32'd14);
    check("model_remu",   ref_model(3'd7, 32'd100, 32'd7), 32'd2);

    repeat (3) @(posedge clk);
    #1;
    check("rst_stall",  32'(bus.stall), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0);
    check("lit_mul", bus.result, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("lit_mulhu", bus.result, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("lit_div", bus.result, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3'd5, 32'd100, 32'd7, 0, 0);
    run_op(3'd7, 32'd100, 32'd7, 2, 0);
    check("lit_remu", bus.result, 32'd2);
    run_op(3'd5, 32'd5, 32'd0, 0, 0);
    check("lit_divu0", bus.result, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd5, 32'd0, 0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("lit_ovf_div", bus.result, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd0, 32'h1234, 32'h10, 1, 10);
    check("lit_flush_keep", bus.result, 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 0, 0);
    check("lit_mul12", bus.result, 32'd12);

    // asynchronous reset in the middle of an iteration
    chk_en = 1'b0;
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_stall",  32'(bus.stall), 32'd0);
    check("midrst_busy",   32'(bus.busy), 32'd0);
    check("midrst_done",   32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    res_old = 32'd0;
    chk_en = 1'b1;
    run_op(3'd0, 32'd6, 32'd7, 0, 0);
    check("lit_after_rst", bus.result, 32'd42);

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      run_op(3'($urandom), rnd_val(), rnd_val(),
             (sel == 0) ? 1 : ((sel == 1) ? 2 : 0), $urandom_range(0, 31));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
